colour_sequencer: RTL and testbench
===================================

// Module: colour_sequencer
// PURPOSE
//  Sequencer for the 3-bit-colour -> 24-bit-RGB converter: steps colour code 0..7 (or 7..0)
//  with a programmable dwell per colour and pulses the converter's enable on every update.
//  Sits between the control/register logic and the converter; drives its colour/enable inputs.
//  Supports one-shot or continuous (looping) sweeps, abort via stop, and completion signalling.
// PARAMETERS
//  DWELL_W  8  width of dwell input and internal dwell counter
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        begin sweep (sampled in IDLE only)
//  stop        in   1        abort sweep (RUN only), priority over all other RUN events
//  dir         in   1        0 = ascending 0->7, 1 = descending 7->0; sampled on accepted start
//  loop        in   1        1 = wrap at sweep end and continue; sampled at every sweep end
//  dwell       in   DWELL_W  extra hold cycles per colour; each colour held dwell+1 cycles
//  colour      out  3        colour code to converter
//  enable      out  1        one-cycle pulse, high in the first cycle of each new colour value
//  busy        out  1        high while in RUN
//  wrap        out  1        one-cycle pulse when a looping sweep restarts
//  done        out  1        one-cycle pulse when a non-looping sweep completes
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, colour=0, enable=0, busy=0, wrap=0, done=0, cnt=0.
//  - All outputs registered. States: IDLE, RUN, DONE (2-bit encoding, default -> IDLE).
//  - IDLE: busy=0, enable=0, colour holds last value. start=1 & stop=0 -> RUN; at that edge
//    colour<=(dir?7:0), enable<=1, cnt<=dwell, latched dir captured. start & stop together -> stay IDLE.
//  - RUN: busy=1. cnt!=0 -> cnt decrements, enable=0, colour holds.
//    cnt==0 and colour not at end (7 asc / 0 desc): colour<=colour+-1, enable<=1, cnt<=dwell.
//    cnt==0 and colour at end: loop=1 -> colour<=start colour, enable<=1, wrap<=1, cnt<=dwell, stay RUN;
//    loop=0 -> DONE, enable=0, colour holds end value.
//  - stop=1 in RUN -> IDLE at next edge; colour holds current value, enable=0, no done/wrap.
//  - start while RUN or DONE ignored; dir changes mid-sweep ignored.
//  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE unconditionally.
//  - dwell re-sampled on each reload; dwell=0 -> new colour every cycle (enable high continuously).
//  - Latency: start edge -> first colour + enable same edge (visible next cycle). Non-looping sweep
//    occupies 8*(dwell+1) cycles in RUN, done asserts the following cycle.
//  - colour arithmetic is 3-bit; wrap handled explicitly, never by natural overflow.
//  - Reset mid-sweep: immediate return to reset values, no done pulse.
// CONFIGURATION
//  SEQ_PAUSE_EN defined: extra input port pause (1 bit). In RUN with pause=1 and stop=0, cnt and colour
//    freeze, enable=0, busy stays 1; on release, sequence resumes from the frozen cnt. stop overrides pause.
//    pause ignored in IDLE/DONE.
//  SEQ_PAUSE_EN undefined: no pause port; RUN advances every cycle as above.
// TESTING
//  1 Assert rst_n=0 mid-activity -> all outputs at reset values immediately, state IDLE.
//  2 dir=0,loop=0,dwell=2,start pulse -> colour 0,1..7 each 3 cycles, 8 enable pulses, done one cycle
//    after 24 RUN cycles; converter rgb checked per colour (0->000000, 1->0000FF ... 7->FFFFFF).
//  3 dir=1,loop=1,dwell=0 -> colour 7,6..0,7,6..., enable continuously high, wrap pulse with each 0->7.
//  4 stop asserted at colour=4 mid-dwell -> next cycle IDLE, busy=0, colour stays 4, no done.
//  5 start re-pulsed during RUN and start+stop together in IDLE -> no effect in both cases.
//  6 (SEQ_PAUSE_EN) pause 5 cycles at colour=3, dwell=3 -> colour 3 held 4+5 cycles total, then advances.

Source files
------------

// File: rtl/colour_sequencer.sv
// Colour-code sweep sequencer driving the 3-bit colour -> 24-bit RGB converter.
// Optional pause input is compiled in when SEQ_PAUSE_EN is defined.
module colour_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_dir,
    input  logic               i_loop,
`ifdef SEQ_PAUSE_EN
    input  logic               i_pause,
`endif
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [2:0]         o_colour,
    output logic               o_enable,
    output logic               o_busy,
    output logic               o_wrap,
    output logic               o_done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e             r_state;
    logic [2:0]         r_colour;
    logic               r_enable;
    logic               r_busy;
    logic               r_wrap;
    logic               r_done;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_dir;

    state_e             w_state_nxt;
    logic [2:0]         w_colour_nxt;
    logic               w_enable_nxt;
    logic               w_wrap_nxt;
    logic               w_done_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_dir_nxt;
    logic               w_at_end;
    logic [2:0]         w_first;
    logic [2:0]         w_step;
    logic               w_hold;

    // End-of-sweep and restart colours follow the direction latched at start.
    assign w_at_end = r_dir ? (r_colour == 3'd0) : (r_colour == 3'd7);
    assign w_first  = r_dir ? 3'd7 : 3'd0;
    assign w_step   = r_dir ? (r_colour - 3'd1) : (r_colour + 3'd1);

`ifdef SEQ_PAUSE_EN
    assign w_hold = i_pause;
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_colour_nxt = r_colour;
        w_enable_nxt = 1'b0;
        w_wrap_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_dir_nxt    = r_dir;

        unique case (r_state)
            StIdle: begin
                if (i_start && !i_stop) begin
                    w_state_nxt  = StRun;
                    w_colour_nxt = i_dir ? 3'd7 : 3'd0;
                    w_enable_nxt = 1'b1;
                    w_cnt_nxt    = i_dwell;
                    w_dir_nxt    = i_dir;
                end
            end
            StRun: begin
                if (i_stop) begin
                    w_state_nxt = StIdle;
                end else if (w_hold) begin
                    w_state_nxt = StRun;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DWELL_W'(1);
                end else if (!w_at_end) begin
                    w_colour_nxt = w_step;
                    w_enable_nxt = 1'b1;
                    w_cnt_nxt    = i_dwell;
                end else if (i_loop) begin
                    w_colour_nxt = w_first;
                    w_enable_nxt = 1'b1;
                    w_wrap_nxt   = 1'b1;
                    w_cnt_nxt    = i_dwell;
                end else begin
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_colour <= 3'd0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_colour <= w_colour_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= (w_state_nxt == StRun);
            r_wrap   <= w_wrap_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
        end
    end

    assign o_colour = r_colour;
    assign o_enable = r_enable;
    assign o_busy   = r_busy;
    assign o_wrap   = r_wrap;
    assign o_done   = r_done;

endmodule

// File: tb/tb_colour_sequencer.sv
// Bench for colour_sequencer: vector table, directed corner sequences and a random run
// against a step-index reference model.
module tb_colour_sequencer;

    localparam int unsigned DW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          dir   = 1'b0;
    logic          lp    = 1'b0;
    logic          pause = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [2:0]    colour;
    logic          enable;
    logic          busy;
    logic          wrap;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 run, 2 done; step counts colours into the sweep.
    int         m_phase;
    int         m_step;
    int         m_left;
    bit         m_dir;
    logic [2:0] e_colour;
    logic       e_enable;
    logic       e_busy;
    logic       e_wrap;
    logic       e_done;

    colour_sequencer #(
        .DWELL_W (DW)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_stop   (stop),
        .i_dir    (dir),
        .i_loop   (lp),
`ifdef SEQ_PAUSE_EN
        .i_pause  (pause),
`endif
        .i_dwell  (dwell),
        .o_colour (colour),
        .o_enable (enable),
        .o_busy   (busy),
        .o_wrap   (wrap),
        .o_done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       dir;
        logic       lp;
        logic [7:0] dwell;
        logic [2:0] colour;
        logic       enable;
        logic       busy;
        logic       wrap;
        logic       done;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_step   = 0;
        m_left   = 0;
        m_dir    = 1'b0;
        e_colour = 3'd0;
        e_enable = 1'b0;
        e_busy   = 1'b0;
        e_wrap   = 1'b0;
        e_done   = 1'b0;
    endtask

    task automatic model_edge();
        e_enable = 1'b0;
        e_wrap   = 1'b0;
        e_done   = 1'b0;
        case (m_phase)
            0: begin
                if (start && !stop) begin
                    m_phase  = 1;
                    m_dir    = dir;
                    m_step   = 0;
                    m_left   = int'(dwell);
                    e_enable = 1'b1;
                end
            end
            1: begin
                if (stop) begin
                    m_phase = 0;
`ifdef SEQ_PAUSE_EN
                end else if (pause) begin
                    m_phase = 1;
`endif
                end else if (m_left > 0) begin
                    m_left--;
                end else if (m_step < 7) begin
                    m_step++;
                    m_left   = int'(dwell);
                    e_enable = 1'b1;
                end else if (lp) begin
                    m_step   = 0;
                    m_left   = int'(dwell);
                    e_enable = 1'b1;
                    e_wrap   = 1'b1;
                end else begin
                    m_phase = 2;
                    e_done  = 1'b1;
                end
            end
            default: m_phase = 0;
        endcase
        e_busy   = (m_phase == 1);
        e_colour = m_dir ? 3'(7 - m_step) : 3'(m_step);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".colour"}, 32'(colour), 32'(e_colour));
        check({tag, ".enable"}, 32'(enable), 32'(e_enable));
        check({tag, ".busy"},   32'(busy),   32'(e_busy));
        check({tag, ".wrap"},   32'(wrap),   32'(e_wrap));
        check({tag, ".done"},   32'(done),   32'(e_done));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".colour"}, 32'(colour), 32'd0);
        check({tag, ".enable"}, 32'(enable), 32'd0);
        check({tag, ".busy"},   32'(busy),   32'd0);
        check({tag, ".wrap"},   32'(wrap),   32'd0);
        check({tag, ".done"},   32'(done),   32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // start+stop in IDLE, dwell 1 descending, start during RUN, stop, then dwell 0.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start;
            stop  = tbl[i].stop;
            dir   = tbl[i].dir;
            lp    = tbl[i].lp;
            dwell = DW'(tbl[i].dwell);
            tick();
            check($sformatf("vec%0d.colour", i), 32'(colour), 32'(tbl[i].colour));
            check($sformatf("vec%0d.enable", i), 32'(enable), 32'(tbl[i].enable));
            check($sformatf("vec%0d.busy", i),   32'(busy),   32'(tbl[i].busy));
            check($sformatf("vec%0d.wrap", i),   32'(wrap),   32'(tbl[i].wrap));
            check($sformatf("vec%0d.done", i),   32'(done),   32'(tbl[i].done));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // Ascending one-shot, each colour held 3 cycles, done after 24 RUN cycles.
        dir   = 1'b0;
        lp    = 1'b0;
        dwell = DW'(2);
        start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                start = (c == 1);
                check($sformatf("asc%0d_%0d.colour", c, k), 32'(colour), 32'(c));
                check($sformatf("asc%0d_%0d.enable", c, k), 32'(enable), 32'(k == 0));
                check($sformatf("asc%0d_%0d.busy", c, k),   32'(busy),   32'd1);
                check($sformatf("asc%0d_%0d.done", c, k),   32'(done),   32'd0);
            end
        end
        start = 1'b0;
        tick();
        check("asc_end.done",   32'(done),   32'd1);
        check("asc_end.busy",   32'(busy),   32'd0);
        check("asc_end.colour", 32'(colour), 32'd7);
        tick();
        check("asc_after.done", 32'(done),   32'd0);

        // Descending loop with dwell 0: enable every cycle, wrap on each 0 -> 7.
        dir   = 1'b1;
        lp    = 1'b1;
        dwell = DW'(0);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            start = 1'b0;
            check($sformatf("loop%0d.colour", i), 32'(colour), 32'(7 - (i % 8)));
            check($sformatf("loop%0d.enable", i), 32'(enable), 32'd1);
            check($sformatf("loop%0d.wrap", i),   32'(wrap),   32'(i > 0 && i % 8 == 0));
            check($sformatf("loop%0d.busy", i),   32'(busy),   32'd1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stop.busy", 32'(busy), 32'd0);

        // Stop at colour 4 in the middle of its dwell.
        dir   = 1'b0;
        lp    = 1'b0;
        dwell = DW'(3);
        start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            start = 1'b0;
        end
        check("pre_stop.colour", 32'(colour), 32'd4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop.busy",   32'(busy),   32'd0);
        check("stop.colour", 32'(colour), 32'd4);
        check("stop.enable", 32'(enable), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_stop%0d.done", i),   32'(done),   32'd0);
            check($sformatf("post_stop%0d.colour", i), 32'(colour), 32'd4);
        end

        // Asynchronous reset in the middle of a sweep.
        start = 1'b1;
        dir   = 1'b1;
        dwell = DW'(1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_vals("midrst_after");

`ifdef SEQ_PAUSE_EN
        // Pause at colour 3: held 4 + 5 cycles before advancing.
        dir   = 1'b0;
        lp    = 1'b0;
        dwell = DW'(3);
        start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            start = 1'b0;
        end
        check("pz_pre.colour", 32'(colour), 32'd3);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("pz%0d.colour", i), 32'(colour), 32'd3);
            check($sformatf("pz%0d.enable", i), 32'(enable), 32'd0);
            check($sformatf("pz%0d.busy", i),   32'(busy),   32'd1);
        end
        pause = 1'b0;
        tick();
        check("pz_rel0.colour", 32'(colour), 32'd3);
        tick();
        check("pz_rel1.colour", 32'(colour), 32'd3);
        tick();
        check("pz_adv.colour", 32'(colour), 32'd4);
        check("pz_adv.enable", 32'(enable), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif

        // Randomised run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(3) == 0);
            stop  = ($urandom_range(15) == 0);
            dir   = 1'($urandom_range(1));
            lp    = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) dwell = DW'($urandom_range(3));
`ifdef SEQ_PAUSE_EN
            pause = ($urandom_range(7) == 0);
`endif
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_reset_vals("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
